demux4_tdm: RTL and testbench
=============================

// Module: demux4_tdm
// PURPOSE
//  Sequential 1-to-4 demultiplexer, the counterpart of the 4:1 output mux.
//  Takes one WIDTH-bit input stream and steers each accepted word into one
//  of four registered output channels a/b/c/d.
//  The target channel is chosen by sel (directed mode) or by an internal
//  round-robin pointer (auto mode). Each channel has a valid/ack handshake
//  toward its consumer.
// PARAMETERS
//  WIDTH  4  data width of din and each channel output a/b/c/d
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous reset, active-low
//  en          in   1      1 = block disabled: outputs cleared, input refused; 0 = run
//  auto        in   1      1 = round-robin target; 0 = target is sel
//  sel         in   2      directed target: 00=a 01=b 10=c 11=d
//  din         in   WIDTH  input word
//  in_valid    in   1      din is valid this cycle
//  in_ready    out  1      block accepts din this cycle (combinational)
//  a,b,c,d     out  WIDTH  channel holding registers
//  vld         out  4      vld[0]=a .. vld[3]=d; channel holds an unconsumed word
//  ack         in   4      consumer of channel i takes the word when ack[i]&vld[i]
//  frame_done  out  1      one-cycle pulse: auto-mode frame a,b,c,d completed
// BEHAVIOUR
//  - Reset (rst_n=0, async): a,b,c,d=0, vld=0, rr_ptr=0, frame_done=0.
//    in_ready=0 while reset is asserted.
//  - en=1, synchronous at each edge:
//    - clear a..d to 0, vld to 0, rr_ptr to 0, frame_done to 0
//    - in_ready=0; ack is ignored.
//    - Mid-frame data is discarded.
//  - Target channel: tgt = auto ? rr_ptr : sel.
//  - in_ready = ~en & (~vld[tgt] | ack[tgt]).
//  - Accept occurs when in_valid & in_ready.
//    - On accept, the channel register for tgt takes din at the next edge
//      and vld[tgt] is set.
//    - Latency is 1 clock from the accept edge to output.
//  - Ack: ack[i]&vld[i] with no refill of channel i clears vld[i].
//    - Data is held, not zeroed.
//    - ack[i] with vld[i]=0 has no effect.
//  - Simultaneous ack[tgt] and accept into tgt: new word is loaded and vld stays 1.
//    The block sustains full throughput on one channel.
//  - Accept is refused while vld[tgt]=1 and ack[tgt]=0 (no overwrite).
//    in_valid may stay high; the word is held upstream.
//  - rr_ptr: 2-bit counter that advances only on an accept in auto mode.
//    - Wraps 3->0.
//    - Directed-mode accepts leave rr_ptr unchanged.
//    - Toggling auto mid-frame keeps rr_ptr.
//  - frame_done:
//    - Registered; high for exactly 1 cycle after the edge that accepts
//      into d in auto mode with rr_ptr=3.
//    - Never pulses in directed mode.
//  - Channels are independent: acks on other channels in the same cycle as
//    an accept are honoured.
//  - in_valid=0: no state change except ack-driven vld clears.
// TESTING
//  1. Reset: hold rst_n=0 with in_valid=1, din=4'hF.
//     -> a..d=0, vld=0000, in_ready=0; after release in_ready=1.
//  2. Directed: auto=0, sel=10, din=4'h9, 1 cycle, ack=0.
//     -> next cycle c=9, vld=0100; a,b,d unchanged.
//  3. Back-pressure: repeat step 2 with din=4'h3, ack=0.
//     -> in_ready=0, c stays 9. Then ack[2]=1 same cycle -> c=3, vld[2]=1.
//  4. Round-robin: auto=1, din=1,2,3,4 on consecutive cycles, ack=1111.
//     -> a=1 b=2 c=3 d=4 in order; frame_done pulses once after 4th; rr_ptr=0.
//  5. Disable mid-frame: auto=1, accept 5,6, then en=1 for 1 cycle.
//     -> vld=0000, a..d=0, in_ready=0; after en=0 next word goes to a.
//  6. Async reset mid-cycle with vld=1111.
//     -> outputs clear immediately without waiting for clk.

Source files
------------

// File: rtl/demux4_tdm.sv
// 1-to-4 TDM demultiplexer. Words go to the channel picked by sel (directed
// mode) or by a round-robin pointer (auto mode). Each channel has a valid/ack handshake.
module demux4_tdm #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             auto,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       vld,
    input  logic [3:0]       ack,
    output logic             frame_done
);

    logic [WIDTH-1:0] ch_q [4];
    logic [WIDTH-1:0] ch_d [4];
    logic [3:0]       vld_q, vld_d;
    logic [1:0]       rr_q, rr_d;
    logic             frame_q, frame_d;
    logic [1:0]       tgt;
    logic             accept;

    // en is an active-high disable. in_ready is also held low while in reset.
    always_comb begin
        tgt      = auto ? rr_q : sel;
        in_ready = rst_n & ~en & (~vld_q[tgt] | ack[tgt]);
        accept   = in_valid & in_ready;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) ch_d[i] = ch_q[i];
        vld_d   = vld_q & ~ack;
        rr_d    = rr_q;
        frame_d = 1'b0;
        if (en) begin
            for (int i = 0; i < 4; i++) ch_d[i] = '0;
            vld_d = '0;
            rr_d  = '0;
        end else if (accept) begin
            // A load into a channel wins over an ack on that channel, so vld stays set.
            ch_d[tgt]  = din;
            vld_d[tgt] = 1'b1;
            if (auto) begin
                rr_d    = rr_q + 2'd1;
                frame_d = (rr_q == 2'd3);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) ch_q[i] <= '0;
            vld_q   <= '0;
            rr_q    <= '0;
            frame_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) ch_q[i] <= ch_d[i];
            vld_q   <= vld_d;
            rr_q    <= rr_d;
            frame_q <= frame_d;
        end
    end

    assign a          = ch_q[0];
    assign b          = ch_q[1];
    assign c          = ch_q[2];
    assign d          = ch_q[3];
    assign vld        = vld_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_demux4_tdm.sv
// Self-checking bench for demux4_tdm. A scoreboard queue holds the expected
// channel and word for each accept and is checked one clock later.
module tb_demux4_tdm;

    logic       clk = 1'b0;
    logic       rst_n, en, auto, in_valid, in_ready, frame_done;
    logic [1:0] sel;
    logic [3:0] din, a, b, c, d, vld, ack;

    typedef struct {
        int         ch;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    demux4_tdm #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .auto(auto), .sel(sel), .din(din),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d),
        .vld(vld), .ack(ack), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] chan(input int i);
        case (i)
            0:       return a;
            1:       return b;
            2:       return c;
            default: return d;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word that must be accepted into channel ch, then check it landed.
    task automatic drive_word(input int ch, input logic [3:0] w);
        exp_t e;
        din      = w;
        in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_ready ch%0d: got %b want 1", ch, in_ready);
        end
        sb.push_back('{ch, w});
        step();
        in_valid = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (chan(e.ch) !== e.data || vld[e.ch] !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_word ch%0d: got %h vld %b want %h vld 1",
                     e.ch, chan(e.ch), vld[e.ch], e.data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; auto = 1'b0; sel = 2'd0;
        din = 4'hF; in_valid = 1'b1; ack = 4'h0;
        step(); step();
        vectors++;
        if ({a, b, c, d, vld, in_ready, frame_done} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_state: got a%h b%h c%h d%h vld%b rdy%b fd%b want all 0",
                     a, b, c, d, vld, in_ready, frame_done);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_directed();
        auto = 1'b0; sel = 2'd2; ack = 4'h0;
        drive_word(2, 4'h9);
        vectors++;
        if (vld !== 4'b0100 || a !== 4'h0 || b !== 4'h0 || d !== 4'h0) begin
            miscompares++;
            $display("FAIL directed_others: got vld%b a%h b%h d%h want 0100 0 0 0",
                     vld, a, b, d);
        end
    endtask

    task automatic test_back_pressure();
        din = 4'h3; in_valid = 1'b1; ack = 4'h0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready: got %b want 0", in_ready);
        end
        step();
        vectors++;
        if (c !== 4'h9 || vld !== 4'b0100) begin
            miscompares++;
            $display("FAIL bp_hold: got c%h vld%b want 9 0100", c, vld);
        end
        ack = 4'b0100;
        drive_word(2, 4'h3);
        ack = 4'b0100;
        step();
        ack = 4'h0;
        vectors++;
        if (vld !== 4'b0000 || c !== 4'h3) begin
            miscompares++;
            $display("FAIL ack_clear: got c%h vld%b want 3 0000", c, vld);
        end
    endtask

    task automatic test_round_robin();
        auto = 1'b1; ack = 4'hF;
        for (int i = 0; i < 4; i++) begin
            drive_word(i, 4'(i + 1));
            vectors++;
            if (frame_done !== (i == 3)) begin
                miscompares++;
                $display("FAIL rr_frame_done word%0d: got %b want %b", i, frame_done, (i == 3));
            end
        end
        step();
        vectors++;
        if (frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_frame_pulse_width: got %b want 0", frame_done);
        end
    endtask

    task automatic test_disable();
        auto = 1'b1; ack = 4'h0;
        drive_word(0, 4'h5);
        drive_word(1, 4'h6);
        en = 1'b1; din = 4'h8; in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL dis_ready: got %b want 0", in_ready);
        end
        step();
        vectors++;
        if ({a, b, c, d, vld, frame_done} !== 21'd0) begin
            miscompares++;
            $display("FAIL dis_clear: got a%h b%h c%h d%h vld%b fd%b want all 0",
                     a, b, c, d, vld, frame_done);
        end
        en = 1'b0; in_valid = 1'b0;
        drive_word(0, 4'hA);
        vectors++;
        if (vld !== 4'b0001) begin
            miscompares++;
            $display("FAIL dis_restart_vld: got %b want 0001", vld);
        end
    endtask

    task automatic test_mode_toggle();
        ack = 4'hF; auto = 1'b1;
        drive_word(1, 4'hB);
        drive_word(2, 4'hC);
        auto = 1'b0; sel = 2'd3;
        drive_word(3, 4'hD);
        vectors++;
        if (frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL directed_no_frame: got %b want 0", frame_done);
        end
        auto = 1'b1; sel = 2'd0;
        drive_word(3, 4'hE);
        vectors++;
        if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL toggle_frame_done: got %b want 1", frame_done);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b0; ack = 4'hF;
        step();
        ack = 4'h0; auto = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            drive_word(i, 4'(i + 1));
        end
        vectors++;
        if (vld !== 4'b1111) begin
            miscompares++;
            $display("FAIL fill_vld: got %b want 1111", vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({a, b, c, d, vld, in_ready, frame_done} !== 22'd0) begin
            miscompares++;
            $display("FAIL async_reset: got a%h b%h c%h d%h vld%b rdy%b want all 0",
                     a, b, c, d, vld, in_ready);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_pressure();
        test_round_robin();
        test_disable();
        test_mode_toggle();
        test_async_reset();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
